// File: rtl/mem_pkg.sv
// Shared definitions for the load/store front end: access encodings, FSM states
// and the request-legality check.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_RMW_MERGE = 2'd2,
    ST_RMW_WRITE = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_BOTH   = 2'd1;
  localparam logic [1:0] ERR_FUNCT3 = 2'd2;
  localparam logic [1:0] ERR_ALIGN  = 2'd3;

  // funct3[1:0] carries the access size; funct3[2] only selects zero-extension.
  function automatic logic [1:0] err_cause(input logic       rd,
                                           input logic       wr,
                                           input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [1:0] cause;
    cause = ERR_NONE;
    if (rd && wr) begin
      cause = ERR_BOTH;
    end else if ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)) begin
      cause = ERR_FUNCT3;
    end else if ((f3[1:0] == 2'b10) && (off != 2'b00)) begin
      cause = ERR_ALIGN;
    end else if ((f3[1:0] == 2'b01) && off[0]) begin
      cause = ERR_ALIGN;
    end else begin
      cause = ERR_NONE;
    end
    return cause;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/half lane steering: extracts and extends load data, and merges sub-word
// store data into an existing RAM word.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = word_i[{off_i, 3'b000} +: 8];
  assign half_s = off_i[1] ? word_i[31:16] : word_i[15:0];

  // Load extraction with sign or zero extension.
  always_comb begin
    load_o = 32'h0000_0000;
    case (funct3_i)
      F3_B:    load_o = {{24{byte_s[7]}}, byte_s};
      F3_BU:   load_o = {24'h00_0000, byte_s};
      F3_H:    load_o = {{16{half_s[15]}}, half_s};
      F3_HU:   load_o = {16'h0000, half_s};
      F3_W:    load_o = word_i;
      default: load_o = 32'h0000_0000;
    endcase
  end

  // Store merge: replace only the addressed lane, keep the rest of the old word.
  always_comb begin
    merge_o = word_i;
    case (funct3_i[1:0])
      2'b00:   merge_o[{off_i, 3'b000} +: 8]     = wdata_i[7:0];
      2'b01:   merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      2'b10:   merge_o = wdata_i;
      default: merge_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for a word-wide single-port RAM without byte enables;
// sub-word stores are done as read-modify-write and stall the pipeline.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  state_e            state_q, state_d;
  logic [ADDR_W+1:0] addr_q;
  logic [2:0]        f3_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merged_q;

  logic              req_s;
  logic [1:0]        cause_s;
  logic [31:0]       load_s;
  logic [31:0]       merge_s;
  logic              unused_addr_bits;

  logic              stall_s, done_s, err_s, we_s;
  logic [31:0]       rdata_s, wdata_s;
  logic [ADDR_W-1:0] raddr_s;

  assign req_s            = mem_read_i | mem_write_i;
  assign cause_s          = err_cause(mem_read_i, mem_write_i, funct3_i, addr_i[1:0]);
  assign unused_addr_bits = ^addr_i[31:ADDR_W+2];

  mem_lane_align u_align (
    .word_i   (ram_rdata_i),
    .wdata_i  (wdata_q),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .load_o   (load_s),
    .merge_o  (merge_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture: later states work only from this latched copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= {(ADDR_W+2){1'b0}};
      f3_q    <= 3'b000;
      wdata_q <= 32'h0000_0000;
    end else if (state_q == ST_IDLE) begin
      addr_q  <= addr_i[ADDR_W+1:0];
      f3_q    <= funct3_i;
      wdata_q <= wdata_i;
    end
  end

  // Merged word for the write phase of a read-modify-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      merged_q <= 32'h0000_0000;
    end else if (state_q == ST_RMW_MERGE) begin
      merged_q <= merge_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!req_s || (cause_s != ERR_NONE)) begin
          state_d = ST_IDLE;
        end else if (mem_read_i) begin
          state_d = ST_LOAD_WAIT;
        end else if (funct3_i[1:0] == 2'b10) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RMW_MERGE;
        end
      end
      ST_LOAD_WAIT: state_d = ST_IDLE;
      ST_RMW_MERGE: state_d = ST_RMW_WRITE;
      ST_RMW_WRITE: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output decode; full words go straight through, sub-word stores read first.
  always_comb begin
    stall_s = 1'b0;
    done_s  = 1'b0;
    err_s   = 1'b0;
    we_s    = 1'b0;
    rdata_s = 32'h0000_0000;
    wdata_s = 32'h0000_0000;
    raddr_s = addr_q[ADDR_W+1:2];
    case (state_q)
      ST_IDLE: begin
        if (!req_s) begin
          raddr_s = addr_q[ADDR_W+1:2];
        end else if (cause_s != ERR_NONE) begin
          err_s = 1'b1;
        end else begin
          raddr_s = addr_i[ADDR_W+1:2];
          if (mem_read_i) begin
            stall_s = 1'b1;
          end else if (funct3_i[1:0] == 2'b10) begin
            we_s    = 1'b1;
            wdata_s = wdata_i;
            done_s  = 1'b1;
          end else begin
            stall_s = 1'b1;
          end
        end
      end
      ST_LOAD_WAIT: begin
        done_s  = 1'b1;
        rdata_s = load_s;
      end
      ST_RMW_MERGE: begin
        stall_s = 1'b1;
      end
      ST_RMW_WRITE: begin
        we_s    = 1'b1;
        wdata_s = merged_q;
        done_s  = 1'b1;
      end
      default: begin
        stall_s = 1'b0;
      end
    endcase
  end

  // Reset forces every output low immediately, abandoning any pending write.
  assign stall_o     = rst_n & stall_s;
  assign done_o      = rst_n & done_s;
  assign err_o       = rst_n & err_s;
  assign ram_we_o    = rst_n & we_s;
  assign rdata_o     = rst_n ? rdata_s : 32'h0000_0000;
  assign ram_wdata_o = rst_n ? wdata_s : 32'h0000_0000;
  assign ram_addr_o  = rst_n ? raddr_s : {ADDR_W{1'b0}};

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a word-level memory model predicts every
// cycle's handshake and data, a bench-side RAM reacts to the DUT's port.
module tb_mem_access_unit;

  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mem_read_i = 1'b0;
  logic              mem_write_i = 1'b0;
  logic [2:0]        funct3_i = 3'b000;
  logic [31:0]       addr_i = 32'h0;
  logic [31:0]       wdata_i = 32'h0;
  logic              stall_o, done_o, err_o, ram_we_o;
  logic [31:0]       rdata_o, ram_wdata_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [31:0]       ram_rdata_i;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_read_i  (mem_read_i),
    .mem_write_i (mem_write_i),
    .funct3_i    (funct3_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .ram_addr_o  (ram_addr_o),
    .ram_we_o    (ram_we_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i)
  );

  // Bench RAM: synchronous 1-cycle read, plus a back-door write port for preloads.
  logic [31:0] ram [0:255];
  logic        bk_we = 1'b0;
  logic [7:0]  bk_addr = 8'h0;
  logic [31:0] bk_data = 32'h0;

  always @(posedge clk) begin
    if (ram_we_o) ram[ram_addr_o[7:0]] <= ram_wdata_o;
    else if (bk_we) ram[bk_addr] <= bk_data;
    ram_rdata_i <= ram[ram_addr_o[7:0]];
  end

  logic [31:0] model_mem [0:255];
  int checks = 0;
  int errors = 0;

  logic              chk_en = 1'b0;
  logic              exp_stall, exp_done, exp_err, exp_we, exp_addr_chk;
  logic [31:0]       exp_rdata, exp_wdata;
  logic [ADDR_W-1:0] exp_addr;
  logic [31:0]       last_rdata = 32'h0;
  logic [31:0]       last_wdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Load result from the size/sign rules, in plain shift-and-mask arithmetic.
  function automatic logic [31:0] load_ref(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] f3);
    int unsigned b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge_ref(input logic [31:0] old_w, input logic [31:0] wd,
                                            input logic [1:0] off, input logic [2:0] f3);
    int unsigned mask, sh;
    if (f3[1:0] == 2'b00) begin
      sh = 8 * off;
      mask = 32'hFF << sh;
    end else begin
      sh = 16 * off[1];
      mask = 32'hFFFF << sh;
    end
    return (old_w & ~mask) | ((wd << sh) & mask);
  endfunction

  // Single compare point, half a cycle away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", {31'b0, stall_o}, {31'b0, exp_stall});
      check("done", {31'b0, done_o}, {31'b0, exp_done});
      check("err", {31'b0, err_o}, {31'b0, exp_err});
      check("ram_we", {31'b0, ram_we_o}, {31'b0, exp_we});
      check("rdata", rdata_o, exp_rdata);
      if (exp_we) check("ram_wdata", ram_wdata_o, exp_wdata);
      if (exp_addr_chk) check("ram_addr", {{(32-ADDR_W){1'b0}}, ram_addr_o},
                              {{(32-ADDR_W){1'b0}}, exp_addr});
      if (done_o) last_rdata = rdata_o;
      if (ram_we_o) last_wdata = ram_wdata_o;
    end
  end

  task automatic clear_exp();
    exp_stall = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_we = 1'b0;
    exp_rdata = 32'h0; exp_wdata = 32'h0; exp_addr_chk = 1'b0; exp_addr = '0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    clear_exp();
    chk_en = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    @(posedge clk); #1;
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    clear_exp();
    chk_en = 1'b1;
    bk_we = 1'b1; bk_addr = idx; bk_data = data;
    model_mem[idx] = data;
    @(posedge clk); #1;
    bk_we = 1'b0;
    @(negedge clk); #1;
  endtask

  // One request, held for its full predicted duration with per-cycle expectations.
  task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    logic        bad;
    int          n;
    logic [7:0]  wi;
    logic [31:0] old_w;
    bad = (rd && wr) || (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
          ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00)) || ((f3[1:0] == 2'b01) && a[0]);
    wi = a[9:2];
    old_w = model_mem[wi];
    if (bad) n = 1;
    else if (rd) n = 2;
    else if (f3[1:0] == 2'b10) n = 1;
    else n = 3;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = a; wdata_i = wd;
      clear_exp();
      exp_addr = a[ADDR_W+1:2];
      if (bad) begin
        exp_err = 1'b1;
      end else if (rd) begin
        if (c == 0) begin
          exp_stall = 1'b1; exp_addr_chk = 1'b1;
        end else begin
          exp_done = 1'b1; exp_rdata = load_ref(old_w, a[1:0], f3);
        end
      end else if (n == 1) begin
        exp_done = 1'b1; exp_we = 1'b1; exp_wdata = wd; exp_addr_chk = 1'b1;
        model_mem[wi] = wd;
      end else if (c < 2) begin
        exp_stall = 1'b1; exp_addr_chk = (c == 0);
      end else begin
        exp_done = 1'b1; exp_we = 1'b1; exp_addr_chk = 1'b1;
        exp_wdata = merge_ref(old_w, wd, a[1:0], f3);
        model_mem[wi] = exp_wdata;
      end
      chk_en = 1'b1;
      @(negedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Outputs must stay low in reset even with a request on the inputs.
    clear_exp();
    exp_addr_chk = 1'b1;
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h8;
    chk_en = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    preload(8'd2, 32'h8765_4321);
    rst_n = 1'b1;
    idle();

    do_req(1'b1, 1'b0, 3'b010, 32'h0000_0008, 32'h0);
    check("lw_lit", last_rdata, 32'h8765_4321);
    do_req(1'b1, 1'b0, 3'b000, 32'h0000_000B, 32'h0);
    check("lb_lit", last_rdata, 32'hFFFF_FF87);
    do_req(1'b1, 1'b0, 3'b100, 32'h0000_000B, 32'h0);
    check("lbu_lit", last_rdata, 32'h0000_0087);
    do_req(1'b1, 1'b0, 3'b001, 32'h0000_000A, 32'h0);
    check("lh_lit", last_rdata, 32'hFFFF_8765);
    do_req(1'b1, 1'b0, 3'b101, 32'h0000_000A, 32'h0);
    check("lhu_lit", last_rdata, 32'h0000_8765);
    do_req(1'b1, 1'b0, 3'b000, 32'h0000_0008, 32'h0);

    do_req(1'b0, 1'b1, 3'b001, 32'h0000_000A, 32'hCAFE_1234);
    check("sh_lit", last_wdata, 32'h1234_4321);
    idle();
    check("sh_ram", ram[2], 32'h1234_4321);
    preload(8'd2, 32'h8765_4321);
    do_req(0, 1'b1, 3'b000, 32'h0000_0009, 32'hFFFF_FFAA);
    check("sb_lit", last_wdata, 32'h8765_AA21);

    do_req(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
    do_req(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0);
    check("sw_lw_lit", last_rdata, 32'hDEAD_BEEF);

    do_req(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0);
    do_req(1'b1, 1'b1, 3'b010, 32'h0000_0008, 32'h1111_1111);
    do_req(1'b1, 1'b0, 3'b011, 32'h0000_0008, 32'h0);
    do_req(1'b1, 1'b0, 3'b001, 32'h0000_0005, 32'h0);
    do_req(1'b0, 1'b1, 3'b001, 32'h0000_0009, 32'h0000_5555);
    do_req(1'b1, 1'b0, 3'b010, 32'hFFFF_0008, 32'h0);
    check("upper_ign_lit", last_rdata, 32'h8765_AA21);

    // Reset while the sub-word store sits in its merge cycle.
    @(posedge clk); #1;
    mem_read_i = 1'b0; mem_write_i = 1'b1; funct3_i = 3'b000;
    addr_i = 32'h0000_0008; wdata_i = 32'h0000_0055;
    clear_exp();
    exp_stall = 1'b1; exp_addr_chk = 1'b1; exp_addr = 14'd2;
    @(negedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    clear_exp();
    exp_addr_chk = 1'b1;
    @(negedge clk); #1;
    @(posedge clk); #1;
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    exp_addr_chk = 1'b0;
    idle();
    check("rst_rmw_ram", ram[2], 32'h8765_AA21);
    do_req(1'b1, 1'b0, 3'b010, 32'h0000_0008, 32'h0);
    check("rst_rmw_lw", last_rdata, 32'h8765_AA21);
    do_req(1'b0, 1'b1, 3'b000, 32'h0000_0008, 32'h0000_0055);
    check("post_rst_sb", last_wdata, 32'h8765_AA55);
    idle();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
